// File: rtl/mem_access_unit.sv
// Memory-stage controller: turns EX/MEM control into a handshaked data-memory request and registers MEM/WB results.
// Optional misalignment trapping is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            wb,
  input  logic [2:0]            mem,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wrt_data,
  input  logic [4:0]            rd,
  input  logic [3:0]            funct,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [1:0]            wbout,
  output logic [4:0]            rdout,
  output logic [DATA_WIDTH-1:0] alures_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t state, state_next;

  logic is_store, is_load, is_op, misaligned;
  logic is_byte, is_half, is_word;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [1:0]            off_c;

  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_off;
  logic [2:0]            req_funct;
  logic                  mis_q;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] shifted, load_ext;
  logic                  unused_bits;

  assign is_store = mem[1];
  assign is_load  = mem[0] & ~mem[1];
  assign is_op    = is_store | is_load;
  assign is_byte  = (funct[1:0] == 2'b00);
  assign is_half  = (funct[1:0] == 2'b01);
  assign is_word  = funct[1];
  assign unused_bits = &{1'b0, mem[2], funct[3]};

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned   = is_op & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
  assign misalign_err = (state == DONE) & mis_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Byte offset only honours the address bits meaningful for the access size.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wrt_data;
    off_c   = 2'b00;
    if (is_byte) begin
      off_c = addr[1:0];
    end else if (is_half) begin
      off_c = {addr[1], 1'b0};
    end
    if (is_store) begin
      case (funct[1:0])
        2'b00: begin
          be_c    = 4'b0001 << addr[1:0];
          wdata_c = {4{wrt_data[7:0]}};
        end
        2'b01: begin
          be_c    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{wrt_data[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = wrt_data;
        end
      endcase
    end
  end

  assign shifted = dmem_rdata >> {req_off, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (req_funct)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    dmem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (is_op) begin
          stall      = 1'b1;
          state_next = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          state_next = req_we ? DONE : RESP;
        end
      end
      RESP: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign dmem_we    = req_we;
  assign dmem_addr  = req_addr;
  assign dmem_be    = req_be;
  assign dmem_wdata = req_wdata;

  // Request fields are latched on acceptance so the memory port stays stable while upstream is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_be     <= 4'b0000;
      req_wdata  <= '0;
      req_off    <= 2'b00;
      req_funct  <= 3'b000;
      mis_q      <= 1'b0;
      hold_data  <= '0;
      wbout      <= 2'b00;
      rdout      <= 5'd0;
      alures_out <= '0;
      rdata_out  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && is_op) begin
        req_we    <= is_store;
        req_addr  <= addr[ADDR_WIDTH+1:2];
        req_be    <= be_c;
        req_wdata <= wdata_c;
        req_off   <= off_c;
        req_funct <= funct[2:0];
        mis_q     <= misaligned;
        hold_data <= '0;
      end
      if (state == RESP && dmem_rvalid) begin
        hold_data <= load_ext;
      end
      if (stall) begin
        wbout <= 2'b00;
      end else if (state == DONE) begin
        wbout      <= mis_q ? 2'b00 : wb;
        rdout      <= rd;
        alures_out <= addr;
        rdata_out  <= hold_data;
      end else begin
        wbout      <= wb;
        rdout      <= rd;
        alures_out <= addr;
        rdata_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard testbench for mem_access_unit; follows MEM_MISALIGN_CHECK_EN when defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb;
  logic [2:0]  mem;
  logic [31:0] addr, wrt_data;
  logic [4:0]  rd;
  logic [3:0]  funct;
  logic        stall, dmem_req, dmem_we;
  logic [8:0]  dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [1:0]  wbout;
  logic [4:0]  rdout;
  logic [31:0] alures_out, rdata_out;
  logic        misalign_err;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        err;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .wb(wb), .mem(mem), .addr(addr), .wrt_data(wrt_data),
    .rd(rd), .funct(funct), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wbout(wbout), .rdout(rdout), .alures_out(alures_out), .rdata_out(rdata_out),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_be(input logic st, input logic [3:0] f, input logic [31:0] a);
    logic [3:0] be;
    be = 4'hF;
    if (st && f[1:0] == 2'b00) begin
      case (a[1:0])
        2'd0: be = 4'b0001;
        2'd1: be = 4'b0010;
        2'd2: be = 4'b0100;
        default: be = 4'b1000;
      endcase
    end else if (st && f[1:0] == 2'b01) begin
      be = a[1] ? 4'b1100 : 4'b0011;
    end
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] f, input logic [31:0] d);
    if (f[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f[1:0] == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] f, input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*a[1:0] +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (f[2:0])
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic model_mis(input logic [3:0] f, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    return (f[1:0] == 2'b01 && a[0]) || (f[1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic [1:0] wbv, input logic [2:0] memv, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rdv, input logic [3:0] f,
                        input int gnt_dly, input int rv_dly, input logic [31:0] mdata, input string name);
    logic st, mis, granted, done, prev_stall;
    int exp_stall, stall_cnt, bubble_bad, req_cyc, resp_cyc;
    req_t rq;
    res_t rs;
    st  = memv[1];
    mis = model_mis(f, a);
    if (!mis) req_q.push_back('{st, a[10:2], model_be(st, f, a), model_wdata(f, wd)});
    res_q.push_back('{mis ? 2'b00 : wbv, rdv, a, (!st && !mis) ? model_load(f, a, mdata) : 32'd0, mis});
    exp_stall = mis ? 1 : (st ? 2 + gnt_dly : 3 + gnt_dly + rv_dly);
    @(negedge clk);
    wb = wbv; mem = memv; addr = a; wrt_data = wd; rd = rdv; funct = f;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    stall_cnt = 0; bubble_bad = 0; req_cyc = 0; resp_cyc = 0;
    granted = 1'b0; done = 1'b0; prev_stall = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (prev_stall && wbout !== 2'b00) bubble_bad++;
      if (stall) stall_cnt++;
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata = $urandom;
      if (dmem_req) begin
        if (req_cyc == 0) begin
          if (req_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL %s unexpected_req: got dmem_req=1, want 0", name);
          end else begin
            rq = req_q[0];
            tests_run++;
            if (dmem_we !== rq.we) begin tests_failed++; $display("[TB] FAIL %s we: got %b want %b", name, dmem_we, rq.we); end
            tests_run++;
            if (dmem_addr !== rq.addr) begin tests_failed++; $display("[TB] FAIL %s dmem_addr: got %0d want %0d", name, dmem_addr, rq.addr); end
            tests_run++;
            if (dmem_be !== rq.be) begin tests_failed++; $display("[TB] FAIL %s be: got %b want %b", name, dmem_be, rq.be); end
            if (rq.we) begin
              tests_run++;
              if (dmem_wdata !== rq.wdata) begin tests_failed++; $display("[TB] FAIL %s wdata: got %h want %h", name, dmem_wdata, rq.wdata); end
            end
          end
        end
        dmem_rvalid = 1'b1;
        if (req_cyc == gnt_dly) begin
          dmem_gnt = 1'b1;
          granted = 1'b1;
          if (req_q.size() > 0) void'(req_q.pop_front());
        end
        req_cyc++;
      end else if (granted && stall) begin
        if (resp_cyc == rv_dly) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = mdata;
        end
        resp_cyc++;
      end
      if (!stall && stall_cnt > 0) begin
        done = 1'b1;
        tests_run++;
        if (misalign_err !== mis) begin tests_failed++; $display("[TB] FAIL %s misalign_err: got %b want %b", name, misalign_err, mis); end
      end
      prev_stall = stall;
      @(negedge clk);
    end
    mem = 3'b000; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    if (!done) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL %s timeout: got no DONE, want DONE within 60 cycles", name);
    end
    rs = res_q.pop_front();
    tests_run++;
    if (wbout !== rs.wb) begin tests_failed++; $display("[TB] FAIL %s wbout: got %b want %b", name, wbout, rs.wb); end
    tests_run++;
    if (rdout !== rs.rd) begin tests_failed++; $display("[TB] FAIL %s rdout: got %0d want %0d", name, rdout, rs.rd); end
    tests_run++;
    if (alures_out !== rs.alu) begin tests_failed++; $display("[TB] FAIL %s alures_out: got %h want %h", name, alures_out, rs.alu); end
    tests_run++;
    if (rdata_out !== rs.rdata) begin tests_failed++; $display("[TB] FAIL %s rdata_out: got %h want %h", name, rdata_out, rs.rdata); end
    tests_run++;
    if (stall_cnt !== exp_stall) begin tests_failed++; $display("[TB] FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, exp_stall); end
    tests_run++;
    if (bubble_bad !== 0) begin tests_failed++; $display("[TB] FAIL %s bubble: got %0d nonzero wbout cycles, want 0", name, bubble_bad); end
  endtask

  task automatic test_reset;
    res_t rs;
    rst = 1'b1; wb = 2'b11; mem = 3'b000; addr = 32'h55; wrt_data = 32'h0; rd = 5'd5; funct = 4'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    res_q.push_back('{2'b00, 5'd0, 32'd0, 32'd0, 1'b0});
    repeat (2) @(negedge clk);
    #1;
    rs = res_q.pop_front();
    tests_run++;
    if (wbout !== rs.wb) begin tests_failed++; $display("[TB] FAIL reset wbout: got %b want %b", wbout, rs.wb); end
    tests_run++;
    if (rdout !== rs.rd) begin tests_failed++; $display("[TB] FAIL reset rdout: got %0d want %0d", rdout, rs.rd); end
    tests_run++;
    if (alures_out !== rs.alu) begin tests_failed++; $display("[TB] FAIL reset alures_out: got %h want %h", alures_out, rs.alu); end
    tests_run++;
    if (rdata_out !== rs.rdata) begin tests_failed++; $display("[TB] FAIL reset rdata_out: got %h want %h", rdata_out, rs.rdata); end
    tests_run++;
    if ({stall, dmem_req, misalign_err} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset ctrl: got %b want 000", {stall, dmem_req, misalign_err}); end
    rst = 1'b0; wb = 2'b00; rd = 5'd0; addr = 32'd0;
  endtask

  task automatic test_idle_passthrough;
    res_t rs;
    @(negedge clk);
    wb = 2'b10; mem = 3'b100; rd = 5'd7; addr = 32'h1234; funct = 4'h2;
    res_q.push_back('{2'b10, 5'd7, 32'h1234, 32'd0, 1'b0});
    @(negedge clk);
    #1;
    rs = res_q.pop_front();
    tests_run++;
    if ({wbout, rdout, alures_out, rdata_out} !== {rs.wb, rs.rd, rs.alu, rs.rdata}) begin
      tests_failed++;
      $display("[TB] FAIL idle_pass: got %b/%0d/%h/%h want %b/%0d/%h/%h", wbout, rdout, alures_out, rdata_out, rs.wb, rs.rd, rs.alu, rs.rdata);
    end
    tests_run++;
    if ({stall, dmem_req} !== 2'b00) begin tests_failed++; $display("[TB] FAIL idle_ctrl: got %b want 00", {stall, dmem_req}); end
    mem = 3'b000;
  endtask

  task automatic test_store;
    run_op(2'b01, 3'b010, 32'h10, 32'hDEADBEEF, 5'd3, 4'b0010, 0, 0, 32'h0, "sw");
    run_op(2'b01, 3'b010, 32'h13, 32'h000000A5, 5'd4, 4'b0000, 0, 0, 32'h0, "sb");
    run_op(2'b00, 3'b011, 32'h2, 32'h1234BEEF, 5'd6, 4'b0001, 2, 0, 32'h0, "sh_gnt_late");
  endtask

  task automatic test_load;
    run_op(2'b11, 3'b001, 32'h21, 32'h0, 5'd8, 4'b0000, 0, 1, 32'h123480FF, "lb");
    run_op(2'b11, 3'b001, 32'h21, 32'h0, 5'd8, 4'b0100, 0, 1, 32'h123480FF, "lbu");
    run_op(2'b11, 3'b101, 32'h02, 32'h0, 5'd9, 4'b0001, 0, 0, 32'h80017FFF, "lh");
    run_op(2'b10, 3'b001, 32'h00, 32'h0, 5'd10, 4'b0101, 1, 2, 32'h80017FFF, "lhu");
    run_op(2'b10, 3'b001, 32'h7FC, 32'h0, 5'd31, 4'b0010, 0, 0, 32'hCAFEF00D, "lw_top");
  endtask

  task automatic test_misalign;
    run_op(2'b11, 3'b001, 32'h06, 32'h0, 5'd11, 4'b0010, 0, 0, 32'hCAFEF00D, "lw_mis");
    run_op(2'b11, 3'b001, 32'h03, 32'h0, 5'd12, 4'b0101, 0, 0, 32'hBEEF1234, "lhu_mis");
    run_op(2'b01, 3'b010, 32'h01, 32'h11223344, 5'd13, 4'b0001, 0, 0, 32'h0, "sh_mis");
  endtask

  task automatic test_reset_mid_access;
    res_t rs;
    int waited;
    @(negedge clk);
    wb = 2'b11; mem = 3'b001; addr = 32'h40; rd = 5'd14; funct = 4'b0010;
    waited = 0;
    #1;
    while (!dmem_req && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    tests_run++;
    if (dmem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid req: got %b want 1", dmem_req); end
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    rst = 1'b1; mem = 3'b000; wb = 2'b00; rd = 5'd0; addr = 32'd0;
    res_q.push_back('{2'b00, 5'd0, 32'd0, 32'd0, 1'b0});
    @(negedge clk);
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    tests_run++;
    if ({stall, dmem_req} !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_mid ctrl: got %b want 00", {stall, dmem_req}); end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    rs = res_q.pop_front();
    tests_run++;
    if ({wbout, rdout, alures_out, rdata_out} !== {rs.wb, rs.rd, rs.alu, rs.rdata}) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid outputs: got %b/%0d/%h/%h want zeros", wbout, rdout, alures_out, rdata_out);
    end
    tests_run++;
    if ({stall, dmem_req} !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_mid after_rvalid: got %b want 00", {stall, dmem_req}); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] m;
    for (int i = 0; i < 8; i++) begin
      m = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
      run_op(2'($urandom), m, {21'd0, 11'($urandom)}, $urandom, 5'($urandom),
             {1'b0, 3'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, "random");
    end
  endtask

  initial begin
    test_reset;
    test_idle_passthrough;
    test_store;
    test_load;
    test_misalign;
    test_reset_mid_access;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage controller; sits downstream of the EX/MEM pipeline register and drives the data-memory port.
- Converts EX/MEM control, address, store data and funct into a handshaked request with byte lanes.
- Sign- or zero-extends load data and registers the results for the WB stage (MEM/WB).
- Holds the upstream pipeline with `stall` while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath width; byte-lane logic requires 32.
- ADDR_WIDTH, 9, word-address width of the data memory; dmem_addr = addr[ADDR_WIDTH+1:2].

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- wb  input  2  WB control from EX/MEM
- mem  input  3  {branch, memwrite, memread} from EX/MEM
- addr  input  DATA_WIDTH  byte address / ALU result
- wrt_data  input  DATA_WIDTH  store data
- rd  input  5  destination register
- funct  input  4  {funct7[5], funct3}; funct[2:0] selects size and sign
- stall  output  1  freeze EX/MEM and earlier stages
- dmem_req  output  1  request valid
- dmem_we  output  1  1 = store
- dmem_addr  output  ADDR_WIDTH  word address
- dmem_be  output  4  byte enables
- dmem_wdata  output  DATA_WIDTH  lane-replicated store data
- dmem_gnt  input  1  request accepted
- dmem_rvalid  input  1  load data valid
- dmem_rdata  input  DATA_WIDTH  load word
- wbout  output  2  registered WB control
- rdout  output  5  registered rd
- alures_out  output  DATA_WIDTH  registered addr (ALU result passthrough)
- rdata_out  output  DATA_WIDTH  registered extended load data
- misalign_err  output  1  one-cycle misalignment flag

Behaviour:
- Clock and reset: clk, rst. Reset is synchronous and active-high.
- Reset behaviour:
  - FSM goes to IDLE.
  - All registered outputs are 0; dmem_req = 0 and stall = 0.
  - Reset mid-access abandons the access; a later dmem_gnt or dmem_rvalid is ignored in IDLE.
- Op decode:
  - store = mem[1]; load = mem[0] & ~mem[1]. memwrite has priority if both are set.
  - mem[2] is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - No load or store: stall = 0; MEM/WB loads wb, rd, addr every cycle; rdata_out = 0.
  - Load or store present: stall = 1; MEM/WB loads a bubble (wbout = 0); next state is REQ.
- REQ:
  - dmem_req = 1, stall = 1; dmem_addr, dmem_we, dmem_be and dmem_wdata are held stable.
  - Waits for dmem_gnt. Store with gnt goes to DONE; load with gnt goes to RESP.
- RESP:
  - dmem_req = 0, stall = 1; waits for dmem_rvalid.
  - On rvalid, the extended data is captured into an internal holding register; next state is DONE.
- DONE:
  - stall = 0; MEM/WB loads wb, rd, addr and the held data; next state is IDLE.
  - Upstream advances on this edge, so the same op is never reissued.
- Bubble rule: wbout = 0 on every edge where stall = 1.
- Minimum stall: 2 cycles for a store (gnt in the first REQ cycle), 3 cycles for a load.
- Store lanes, by funct[1:0]:
  - SB (00): be = 1 << addr[1:0]; wdata = {4{wrt_data[7:0]}}.
  - SH (01): be = addr[1] ? 1100 : 0011; wdata = {2{wrt_data[15:0]}}.
  - SW (10): be = 1111; wdata = wrt_data.
- Load extract: shift dmem_rdata right by 8*addr[1:0], then extend by funct[2:0]:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other codes are treated as LW.
- Loads drive dmem_be = 1111 and dmem_we = 0.
- dmem_rvalid outside RESP is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - Misaligned accesses are half with addr[0] = 1, or word with addr[1:0] != 00.
  - A misaligned access skips REQ and RESP: IDLE → DONE, with 1 stall cycle and no dmem_req.
  - In DONE, MEM/WB loads wbout = 0, and misalign_err = 1 for one cycle.
- Undefined:
  - misalign_err is tied to 0.
  - Low address bits beyond the access size are ignored: half uses addr[1] only, word ignores addr[1:0].

Test Plan:
- SW addr = 0x0000_0010, wrt_data = 0xDEADBEEF, gnt in first REQ cycle → dmem_addr = 4, be = 1111, wdata = 0xDEADBEEF; stall high 2 cycles; wbout = 0 during stall.
- SB addr = 0x13, wrt_data = 0x0000_00A5 → be = 1000, wdata = 0xA5A5A5A5, dmem_we = 1.
- LB addr = 0x21, rdata = 0x1234_80FF, rvalid 2 cycles after gnt → rdata_out = 0xFFFF_FF80; with LBU → 0x0000_0080; stall high 4 cycles.
- LH addr = 0x02, rdata = 0x8001_7FFF → rdata_out = 0xFFFF_8001; rd and wb appear on rdout/wbout in the DONE cycle.
- Load in RESP, rst asserted for 1 cycle, then rvalid → outputs stay 0, FSM in IDLE, stall = 0, rvalid ignored.
- With MEM_MISALIGN_CHECK_EN: LW addr = 0x06 → no dmem_req, misalign_err = 1 for 1 cycle, wbout = 0. Without the macro: dmem_addr = 1, be = 1111, normal load.
